// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states,
// instruction size, default halt opcode and branch-offset helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam int unsigned INSN_BYTES      = 4;
    localparam logic [5:0]  HALT_OPCODE_DEF = 6'h3F;

    // Signed word offset to signed byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] branch_byte_offset(input logic [15:0] word_off);
        return {{14{word_off[15]}}, word_off, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump target beats branch target beats sequential PC+4.
// Redirect targets are computed relative to the address of the instruction
// held in IR, not the current fetch PC.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_pc_i,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic [15:0] branch_offset_i,
    input  logic [25:0] jump_target_i,
    output logic [31:0] next_pc_o,
    output logic        redirect_o
);

    logic [31:0] pc_plus4;
    logic [31:0] ir_pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;

    assign pc_plus4      = pc_i + 32'(INSN_BYTES);
    assign ir_pc_plus4   = ir_pc_i + 32'(INSN_BYTES);
    assign branch_target = ir_pc_plus4 + branch_byte_offset(branch_offset_i);
    assign jump_addr     = {ir_pc_plus4[31:28], jump_target_i, 2'b00};

    // Priority mux of the candidate next PCs.
    always_comb begin
        next_pc_o  = pc_plus4;
        redirect_o = 1'b0;
        if (jump_i) begin
            next_pc_o  = jump_addr;
            redirect_o = 1'b1;
        end else if (branch_i) begin
            next_pc_o  = branch_target;
            redirect_o = 1'b1;
        end else begin
            next_pc_o  = pc_plus4;
            redirect_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, addresses the instruction ROM and
// registers the returned word into IR. RUN/HALT/FAULT state machine; HALT and
// FAULT are sticky until Reset.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned ROM_BYTES   = 128,
    parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] InsAddr,
    input  logic [31:0] InsData,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic        halted,
    output logic        addr_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  ir_pc_q, ir_pc_d;
    logic         ir_valid_q, ir_valid_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;

    logic [32:0]  pc_last_byte;
    logic         fetch_legal;
    logic         halt_in_ir;
    logic         jump_ok;
    logic         branch_ok;
    logic [31:0]  next_pc;
    logic         redirect;

    // Last byte of the word is checked with an extra bit so PC near 2^32
    // cannot wrap into a legal-looking address.
    assign pc_last_byte = {1'b0, pc_q} + 33'd3;
    assign fetch_legal  = (pc_q[1:0] == 2'b00) && (pc_last_byte < 33'(ROM_BYTES));
    assign halt_in_ir   = ir_valid_q && (ir_q[31:26] == HALT_OPCODE);

    // Redirects belong to the instruction in IR, so a bubble cannot issue one.
    assign jump_ok   = jump && ir_valid_q;
    assign branch_ok = branch_taken && ir_valid_q;

    next_pc_sel u_next_pc_sel (
        .pc_i            (pc_q),
        .ir_pc_i         (ir_pc_q),
        .jump_i          (jump_ok),
        .branch_i        (branch_ok),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .next_pc_o       (next_pc),
        .redirect_o      (redirect)
    );

    // Next-state logic: stall > halt > illegal fetch > redirect > sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d       = pc_q;
                    ir_d       = ir_q;
                    ir_pc_d    = ir_pc_q;
                    ir_valid_d = ir_valid_q;
                end else if (halt_in_ir) begin
                    state_d    = ST_HALT;
                    ir_valid_d = 1'b0;
                end else if (!fetch_legal) begin
                    state_d    = ST_FAULT;
                    ir_valid_d = 1'b0;
                end else begin
                    // The word fetched this cycle is wrong-path when redirecting.
                    pc_d       = next_pc;
                    ir_d       = InsData;
                    ir_pc_d    = pc_q;
                    ir_valid_d = !redirect;
                end
            end
            ST_HALT: begin
                ir_valid_d = 1'b0;
            end
            ST_FAULT: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_FAULT;
                ir_valid_d = 1'b0;
            end
        endcase
        halted_d = (state_d == ST_HALT);
        fault_d  = (state_d == ST_FAULT);
    end

    // State, PC and instruction registers with asynchronous reset.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ir_q       <= 32'h0000_0000;
            ir_pc_q    <= 32'h0000_0000;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign InsAddr    = pc_q;
    assign IR         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;
    assign halted     = halted_q;
    assign addr_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM, expected post-edge outputs queued
// as each cycle's stimulus is driven and compared after the edge.
module tb_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] InsAddr;
    logic [31:0] InsData;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        halted;
    logic        addr_fault;

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] irpc;
        logic        chk_irpc;
        logic        valid;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  rom [0:127];

    fetch_unit dut (
        .CLK           (CLK),
        .Reset         (Reset),
        .InsAddr       (InsAddr),
        .InsData       (InsData),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .IR            (IR),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .halted        (halted),
        .addr_fault    (addr_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Big-endian combinational ROM; out-of-range reads return zero.
    always_comb begin
        InsData = 32'h0000_0000;
        if (InsAddr < 32'd125) begin
            InsData = {rom[InsAddr[6:0]], rom[InsAddr[6:0] + 7'd1],
                       rom[InsAddr[6:0] + 7'd2], rom[InsAddr[6:0] + 7'd3]};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        rom[a]     = w[31:24];
        rom[a + 1] = w[23:16];
        rom[a + 2] = w[15:8];
        rom[a + 3] = w[7:0];
    endtask

    task automatic push_exp(input string tag, input logic [31:0] addr, input logic [31:0] ir,
                            input logic [31:0] irpc, input logic chk_irpc, input logic valid,
                            input logic h, input logic f);
        exp_t e;
        e.tag = tag; e.addr = addr; e.ir = ir; e.irpc = irpc; e.chk_irpc = chk_irpc;
        e.valid = valid; e.halted = h; e.fault = f;
        exp_q.push_back(e);
    endtask

    task automatic compare_front();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, ".InsAddr"}, InsAddr, e.addr);
            check_eq({e.tag, ".IR"}, IR, e.ir);
            if (e.chk_irpc) check_eq({e.tag, ".ir_pc"}, ir_pc, e.irpc);
            check_eq({e.tag, ".ir_valid"}, {31'd0, ir_valid}, {31'd0, e.valid});
            check_eq({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.halted});
            check_eq({e.tag, ".addr_fault"}, {31'd0, addr_fault}, {31'd0, e.fault});
        end
    endtask

    // Queue the expectation for the coming edge, then compare just after it.
    task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] ir,
                        input logic [31:0] irpc, input logic chk_irpc, input logic valid,
                        input logic h, input logic f);
        push_exp(tag, addr, ir, irpc, chk_irpc, valid, h, f);
        @(posedge CLK);
        #1;
        compare_front();
    endtask

    task automatic set_in(input logic s, input logic b, input logic [15:0] off,
                          input logic j, input logic [25:0] tgt);
        stall = s; branch_taken = b; branch_offset = off; jump = j; jump_target = tgt;
    endtask

    // Reset pulse placed between clock edges; checks the immediate reset values.
    task automatic reset_pulse(input string tag);
        Reset = 1'b1;
        #1;
        push_exp(tag, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare_front();
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 128; a += 4) put_word(a, 32'h2000_0000 | a);
        put_word(0, 32'h2001_0005);
        put_word(4, 32'h2002_0007);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

        // Straight-line fetch from reset
        Reset = 1'b1;
        #3;
        push_exp("reset", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        compare_front();
        #3;
        Reset = 1'b0;
        step("seq1", 32'h4, 32'h2001_0005, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("seq2", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

        // Stall three cycles at PC=8; a branch during stall is ignored
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
        step("stall1", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        step("stall2", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        set_in(1'b1, 1'b1, 16'h0010, 1'b0, 26'h0);
        step("stall3", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        step("resume", 32'hC, 32'h2000_0008, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);

        // Backward branch from ir_pc=8 by -2 words -> 4
        set_in(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0);
        step("br_bubble", 32'h4, 32'h2000_000C, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        step("br_target", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        step("seq3", 32'hC, 32'h2000_0008, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);
        step("seq4", 32'h10, 32'h2000_000C, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        step("seq5", 32'h14, 32'h2000_0010, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);

        // Jump and branch together from ir_pc=0x10: jump wins -> 0x18
        set_in(1'b0, 1'b1, 16'h0005, 1'b1, 26'h6);
        step("jmp_bubble", 32'h18, 32'h2000_0014, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Redirects still asserted during the bubble are ignored
        step("jmp_target", 32'h1C, 32'h2000_0018, 32'h18, 1'b1, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

        // Halt instruction at 0xC
        put_word(12, 32'hFC00_0000);
        reset_pulse("rst_halt");
        step("h_seq1", 32'h4, 32'h2001_0005, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("h_seq2", 32'h8, 32'h2002_0007, 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
        step("h_seq3", 32'hC, 32'h2000_0008, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);
        step("h_insn", 32'h10, 32'hFC00_0000, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
        step("halted1", 32'h10, 32'hFC00_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("halted2", 32'h10, 32'hFC00_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        put_word(12, 32'h2000_000C);

        // Branch from ir_pc=0 by +31 words -> 0x80, out of ROM
        reset_pulse("rst_fault");
        step("f_seq1", 32'h4, 32'h2001_0005, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_in(1'b0, 1'b1, 16'h001F, 1'b0, 26'h0);
        step("f_redirect", 32'h80, 32'h2002_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
        step("fault1", 32'h80, 32'h2002_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("fault2", 32'h80, 32'h2002_0007, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset clears FAULT without a clock edge
        reset_pulse("rst_async");
        step("post_rst", 32'h4, 32'h2001_0005, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
